stream_mux_arb: RTL and testbench
=================================

Name: stream_mux_arb

Overview:
- Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the 2:1 combinational bus mux, used where several producers share one consumer: result bus, memory-request port, or debug/trace funnel in the RISC-V datapath.
- Source is chosen either by an explicit select input or by a built-in round-robin arbiter.
- Output is registered: one-cycle latency, full throughput.

Parameters:
- NrOfBits, 32, data width W.
- NrOfInputs, 4, channel count N (2..16).
- SelBits, 2, select/source-index width; must equal clog2(NrOfInputs).
- ArbMode, 0, 0 = explicit select (Sel), 1 = round-robin.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Enable  in  1  when 0, no new input is accepted; the output register still drains.
- In_Valid  in  N  per-channel valid.
- In_Data  in  N*W  channel i occupies bits [i*W +: W].
- In_Ready  out  N  per-channel ready, at most one bit high.
- Sel  in  SelBits  channel select; used only when ArbMode=0.
- Out_Valid  out  1  output register holds a word.
- Out_Data  out  W  registered data.
- Out_Src  out  SelBits  index of the channel that supplied Out_Data.
- Out_Ready  in  1  consumer accepts the word.

Behaviour:
- Reset (async, Reset_n=0): Out_Valid=0, Out_Data=0, Out_Src=0, RR pointer Last=N-1 so the first grant favours channel 0. In_Ready is 0 throughout reset.
- Release is synchronous to Clock; nothing is accepted in the first cycle after deassertion if Enable=0.
- Slot free: SlotFree = ~Out_Valid | Out_Ready. This is combinational and allows back-to-back transfers.
- Grant, ArbMode=0: Gnt = Sel if Sel < N, otherwise no grant. In_Valid is not consulted for the grant.
- Grant, ArbMode=1: Gnt = first i with In_Valid[i]=1, searching Last+1, Last+2, ... mod N. No grant if all In_Valid=0.
- In_Ready[i] = Enable & SlotFree & grant-exists & (Gnt==i).
  - In_Ready may depend on In_Valid in ArbMode 1 only.
  - In_Ready never depends on Out_Valid of the same cycle other than through SlotFree.
- Accept = In_Valid[Gnt] & In_Ready[Gnt].
- On an accept clock edge:
  - Out_Data <= In_Data[Gnt], Out_Src <= Gnt, Out_Valid <= 1.
  - Last <= Gnt, in ArbMode 1 only.
- Output consumed without a new accept (Out_Valid & Out_Ready & ~Accept): Out_Valid <= 0. Out_Data and Out_Src hold their last values.
- Simultaneous consume and accept: Out_Valid stays 1 and the new word replaces the old one. No bubble.
- Stall (Out_Valid & ~Out_Ready): Out_Data and Out_Src are held stable, and all In_Ready are 0.
- Enable=0 mid-stream:
  - A word already in the register is kept and drains normally.
  - No input is accepted.
  - The RR pointer is frozen.
- Sel may change on any cycle; it affects only the grant of that cycle. An out-of-range Sel stalls all inputs and never corrupts the register.
- Fairness (ArbMode 1): with all N channels continuously valid and Out_Ready=1, grants rotate 0,1,...,N-1,0. Each channel is served exactly once per N accepts.
- Latency: input accepted at edge k is visible on Out_Data at k (registered). Throughput is 1 word per cycle.
- Width rules: no arithmetic on data. The pointer increment wraps modulo N, which also holds for non-power-of-two N.

Decomposition:
- Shared package: ARB_MODE_SELECT=0, ARB_MODE_RR=1, and a clog2 helper/constant used to check SelBits.
- One sub-module, rr_arbiter (N, SelBits):
  - Inputs: Req[N], Advance, Clock, Reset_n.
  - Outputs: Gnt index and GntValid.
  - Contains the Last pointer and its async reset.
- In ArbMode 0 the arbiter is bypassed by a generate branch.

Test Plan:
- Reset/idle: hold Reset_n=0 for 3 cycles with In_Valid=4'b1111 -> Out_Valid=0, Out_Data=0, In_Ready=0. After release, first RR grant goes to channel 0.
- Explicit select (ArbMode=0): Sel=2, In_Data[2]=32'hDEADBEEF, In_Valid=4'b0100, Out_Ready=1 -> In_Ready=4'b0100; next cycle Out_Valid=1, Out_Data=32'hDEADBEEF, Out_Src=2. Sel=2 with In_Valid[2]=0 -> no transfer.
- Round-robin fairness (ArbMode=1): all four channels valid with distinct data, Out_Ready=1 for 8 cycles -> Out_Src sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: Out_Ready=0 for 5 cycles while channel 1 is valid -> Out_Data/Out_Src frozen and In_Ready=0. Then Out_Ready=1 -> held word consumed and new word loaded on the same edge (Out_Valid stays 1).
- Enable drop: register full, Enable=0, Out_Ready=1 -> word drains, Out_Valid=0 next cycle, no accepts. Restoring Enable resumes at the frozen pointer+1.
- Async reset mid-transfer: assert Reset_n between edges while Out_Valid=1 -> Out_Valid falls immediately without a clock; pointer returns to N-1.

Source files
------------

// File: rtl/stream_mux_arb_pkg.sv
// Shared constants and helpers for the stream_mux_arb multiplexer/arbiter slice.
// Exposes the arbitration mode encodings and a clog2 used to validate SelBits.
package stream_mux_arb_pkg;

  localparam int ARB_MODE_SELECT = 0;
  localparam int ARB_MODE_RR     = 1;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// Handshake bundle between N producers and one consumer of stream_mux_arb.
// Channel i of In_Data occupies bits [i*NrOfBits +: NrOfBits].
interface stream_mux_arb_if #(
  parameter int NrOfBits   = 32,
  parameter int NrOfInputs = 4,
  parameter int SelBits    = 2
);
  logic [NrOfInputs-1:0]          In_Valid;
  logic [NrOfInputs*NrOfBits-1:0] In_Data;
  logic [NrOfInputs-1:0]          In_Ready;
  logic                           Out_Valid;
  logic [NrOfBits-1:0]            Out_Data;
  logic [SelBits-1:0]             Out_Src;
  logic                           Out_Ready;

  modport master (
    output In_Valid, In_Data, Out_Ready,
    input  In_Ready, Out_Valid, Out_Data, Out_Src
  );

  modport slave (
    input  In_Valid, In_Data, Out_Ready,
    output In_Ready, Out_Valid, Out_Data, Out_Src
  );
endinterface

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last granted index.
// Last resets to N-1 so that channel 0 is favoured first; wraps modulo N for any N.
module rr_arbiter #(
  parameter int NrOfInputs = 4,
  parameter int SelBits    = 2
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [NrOfInputs-1:0] Req,
  input  logic                  Advance,
  output logic [SelBits-1:0]    Gnt,
  output logic                  GntValid
);

  logic [SelBits-1:0] r_last;
  logic [SelBits:0]   w_cand;

  always_comb begin
    Gnt      = '0;
    GntValid = 1'b0;
    w_cand   = '0;
    for (int k = 1; k <= NrOfInputs; k++) begin
      // Extra bit keeps Last+k from overflowing before the modulo-N fold.
      w_cand = {1'b0, r_last} + (SelBits + 1)'(k);
      if (w_cand >= (SelBits + 1)'(NrOfInputs)) w_cand = w_cand - (SelBits + 1)'(NrOfInputs);
      if (!GntValid && Req[w_cand[SelBits-1:0]]) begin
        Gnt      = w_cand[SelBits-1:0];
        GntValid = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_last <= SelBits'(NrOfInputs - 1);
    end else if (Advance) begin
      r_last <= Gnt;
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-input registered stream multiplexer with explicit-select or round-robin source choice.
// One word of output storage; a consume and a new accept may share a clock edge.
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter int NrOfBits   = 32,
  parameter int NrOfInputs = 4,
  parameter int SelBits    = 2,
  parameter int ArbMode    = 0
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               Enable,
  input  logic [SelBits-1:0] Sel,
  stream_mux_arb_if.slave    bus
);

  if (SelBits != clog2_f(NrOfInputs)) begin : g_bad_selbits
    $error("stream_mux_arb: SelBits must equal clog2(NrOfInputs)");
  end

  logic                r_out_valid;
  logic [NrOfBits-1:0] r_out_data;
  logic [SelBits-1:0]  r_out_src;

  logic                w_slot_free;
  logic [SelBits-1:0]  w_gnt;
  logic                w_gnt_valid;
  logic                w_accept;
  logic [NrOfBits-1:0] w_sel_data;
  logic [NrOfBits-1:0] w_chan_data [NrOfInputs];
  logic [NrOfInputs-1:0] w_in_ready;

  assign w_slot_free = ~r_out_valid | bus.Out_Ready;

  if (ArbMode == ARB_MODE_RR) begin : g_rr
    logic w_unused_sel;
    assign w_unused_sel = ^Sel;

    rr_arbiter #(
      .NrOfInputs (NrOfInputs),
      .SelBits    (SelBits)
    ) u_rr_arbiter (
      .Clock    (Clock),
      .Reset_n  (Reset_n),
      .Req      (bus.In_Valid),
      .Advance  (w_accept),
      .Gnt      (w_gnt),
      .GntValid (w_gnt_valid)
    );
  end else begin : g_sel
    // Out-of-range select simply yields no grant, so nothing is accepted.
    assign w_gnt       = Sel;
    assign w_gnt_valid = (int'(Sel) < NrOfInputs);
  end

  for (genvar gi = 0; gi < NrOfInputs; gi++) begin : g_chan
    assign w_chan_data[gi] = bus.In_Data[gi*NrOfBits +: NrOfBits];
    // Reset_n gating keeps every ready low while the block is held in reset.
    assign w_in_ready[gi]  = Reset_n & Enable & w_slot_free & w_gnt_valid &
                             (w_gnt == SelBits'(gi));
  end

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NrOfInputs; i++) begin
      if (w_gnt == SelBits'(i)) w_sel_data = w_chan_data[i];
    end
  end

  assign w_accept = |(w_in_ready & bus.In_Valid);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_src   <= w_gnt;
    end else if (bus.Out_Ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.In_Ready  = w_in_ready;
  assign bus.Out_Valid = r_out_valid;
  assign bus.Out_Data  = r_out_data;
  assign bus.Out_Src   = r_out_src;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench: explicit-select and round-robin instances (N=4) plus an N=3 select
// instance for the out-of-range select case, driven from a vector table and sequences.
module tb_stream_mux_arb;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  logic [1:0] sel_a, sel_r, sel_c;

  always #5 clk = ~clk;

  stream_mux_arb_if #(.NrOfBits(32), .NrOfInputs(4), .SelBits(2)) if_a ();
  stream_mux_arb_if #(.NrOfBits(32), .NrOfInputs(4), .SelBits(2)) if_r ();
  stream_mux_arb_if #(.NrOfBits(8),  .NrOfInputs(3), .SelBits(2)) if_c ();

  stream_mux_arb #(.NrOfBits(32), .NrOfInputs(4), .SelBits(2), .ArbMode(0)) dut_sel (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .Sel(sel_a), .bus(if_a.slave));
  stream_mux_arb #(.NrOfBits(32), .NrOfInputs(4), .SelBits(2), .ArbMode(1)) dut_rr (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .Sel(sel_r), .bus(if_r.slave));
  stream_mux_arb #(.NrOfBits(8), .NrOfInputs(3), .SelBits(2), .ArbMode(0)) dut_n3 (
    .Clock(clk), .Reset_n(rst_n), .Enable(en), .Sel(sel_c), .bus(if_c.slave));

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic        out_ready;
    logic        enable;
    logic [3:0]  exp_ready;
    logic        exp_ovalid;
    logic [31:0] exp_data;
    logic [1:0]  exp_src;
  } vec_t;

  vec_t vecs [9];
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rr_data [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'd2, 4'b0100, 1'b1, 1'b1, 4'b0100, 1'b1, 32'hDEADBEEF, 2'd2};
    vecs[1] = '{2'd2, 4'b0000, 1'b1, 1'b1, 4'b0100, 1'b0, 32'hDEADBEEF, 2'd2};
    vecs[2] = '{2'd0, 4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 32'h11111111, 2'd0};
    vecs[3] = '{2'd3, 4'b1000, 1'b0, 1'b1, 4'b0000, 1'b1, 32'h11111111, 2'd0};
    vecs[4] = '{2'd3, 4'b1000, 1'b1, 1'b1, 4'b1000, 1'b1, 32'h44444444, 2'd3};
    vecs[5] = '{2'd1, 4'b0010, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h44444444, 2'd3};
    vecs[6] = '{2'd1, 4'b0010, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h44444444, 2'd3};
    vecs[7] = '{2'd1, 4'b0010, 1'b0, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1};
    vecs[8] = '{2'd1, 4'b0010, 1'b1, 1'b1, 4'b0010, 1'b1, 32'h22222222, 2'd1};
    for (int i = 0; i < 4; i++) rr_data[i] = 32'hC0DE_0000 + 32'(i);

    sel_a = 2'd0; sel_r = 2'd0; sel_c = 2'd0;
    if_a.In_Data = {32'h44444444, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    if_r.In_Data = {rr_data[3], rr_data[2], rr_data[1], rr_data[0]};
    if_c.In_Data = {8'h52, 8'h51, 8'h50};
    if_a.In_Valid = 4'b1111; if_r.In_Valid = 4'b1111; if_c.In_Valid = 3'b000;
    if_a.Out_Ready = 1'b1; if_r.Out_Ready = 1'b1; if_c.Out_Ready = 1'b1;

    // Reset held three cycles with all inputs valid
    repeat (3) tick();
    chk("rst_ovalid", 32'(if_a.Out_Valid), 32'd0);
    chk("rst_odata", if_a.Out_Data, 32'd0);
    chk("rst_osrc", 32'(if_r.Out_Src), 32'd0);
    chk("rst_ready_sel", 32'(if_a.In_Ready), 32'd0);
    chk("rst_ready_rr", 32'(if_r.In_Ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rr_first_grant", 32'(if_r.In_Ready), 32'b0001);
    $display("release: rr ready=%b", if_r.In_Ready);
    if_a.In_Valid = 4'b0000; if_r.In_Valid = 4'b0000;

    // Explicit-select vector table
    for (int v = 0; v < 9; v++) begin
      sel_a = vecs[v].sel;
      if_a.In_Valid = vecs[v].in_valid;
      if_a.Out_Ready = vecs[v].out_ready;
      en = vecs[v].enable;
      #1;
      chk($sformatf("v%0d_ready", v), 32'(if_a.In_Ready), 32'(vecs[v].exp_ready));
      tick();
      chk($sformatf("v%0d_ovalid", v), 32'(if_a.Out_Valid), 32'(vecs[v].exp_ovalid));
      chk($sformatf("v%0d_odata", v), if_a.Out_Data, vecs[v].exp_data);
      chk($sformatf("v%0d_osrc", v), 32'(if_a.Out_Src), 32'(vecs[v].exp_src));
      $display("vec %0d: sel=%0d valid=%b en=%b -> ovalid=%b data=%h src=%0d",
               v, vecs[v].sel, vecs[v].in_valid, vecs[v].enable,
               if_a.Out_Valid, if_a.Out_Data, if_a.Out_Src);
    end

    // Round-robin fairness: all valid, consumer always ready
    en = 1'b1;
    if_r.In_Valid = 4'b1111;
    if_r.Out_Ready = 1'b1;
    #1;
    chk("rr_ready0", 32'(if_r.In_Ready), 32'b0001);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("rr%0d_ovalid", k), 32'(if_r.Out_Valid), 32'd1);
      chk($sformatf("rr%0d_osrc", k), 32'(if_r.Out_Src), 32'(k % 4));
      chk($sformatf("rr%0d_odata", k), if_r.Out_Data, rr_data[k % 4]);
      $display("rr accept %0d: src=%0d data=%h", k, if_r.Out_Src, if_r.Out_Data);
    end

    // Backpressure: hold channel 3's word for five cycles while channel 1 waits
    if_r.In_Valid = 4'b0010;
    if_r.Out_Ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_ready", k), 32'(if_r.In_Ready), 32'd0);
      tick();
      chk($sformatf("bp%0d_ovalid", k), 32'(if_r.Out_Valid), 32'd1);
      chk($sformatf("bp%0d_osrc", k), 32'(if_r.Out_Src), 32'd3);
      chk($sformatf("bp%0d_odata", k), if_r.Out_Data, rr_data[3]);
      $display("stall %0d: src=%0d data=%h", k, if_r.Out_Src, if_r.Out_Data);
    end
    if_r.Out_Ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(if_r.In_Ready), 32'b0010);
    tick();
    chk("bp_release_ovalid", 32'(if_r.Out_Valid), 32'd1);
    chk("bp_release_osrc", 32'(if_r.Out_Src), 32'd1);
    chk("bp_release_odata", if_r.Out_Data, rr_data[1]);
    $display("bp release: src=%0d data=%h", if_r.Out_Src, if_r.Out_Data);

    // Enable drop: word drains, pointer frozen at 1
    en = 1'b0;
    if_r.In_Valid = 4'b1111;
    #1;
    chk("en0_ready_a", 32'(if_r.In_Ready), 32'd0);
    tick();
    chk("en0_drained", 32'(if_r.Out_Valid), 32'd0);
    #1;
    chk("en0_ready_b", 32'(if_r.In_Ready), 32'd0);
    tick();
    chk("en0_idle", 32'(if_r.Out_Valid), 32'd0);
    en = 1'b1;
    #1;
    chk("en1_ready", 32'(if_r.In_Ready), 32'b0100);
    tick();
    chk("en1_osrc", 32'(if_r.Out_Src), 32'd2);
    $display("enable restored: src=%0d valid=%b", if_r.Out_Src, if_r.Out_Valid);

    // Asynchronous reset between edges while a word is held
    if_r.Out_Ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 32'(if_r.Out_Valid), 32'd0);
    chk("arst_odata", if_r.Out_Data, 32'd0);
    chk("arst_ready", 32'(if_r.In_Ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("arst_ptr_grant", 32'(if_r.In_Ready), 32'b0001);
    $display("async reset: ready after release=%b", if_r.In_Ready);
    if_r.In_Valid = 4'b0000;

    // Out-of-range select on a three-channel instance
    if_c.In_Valid = 3'b111;
    if_c.Out_Ready = 1'b1;
    sel_c = 2'd3;
    #1;
    chk("n3_oor_ready", 32'(if_c.In_Ready), 32'd0);
    tick();
    chk("n3_oor_ovalid", 32'(if_c.Out_Valid), 32'd0);
    sel_c = 2'd2;
    #1;
    chk("n3_sel2_ready", 32'(if_c.In_Ready), 32'b100);
    tick();
    chk("n3_sel2_ovalid", 32'(if_c.Out_Valid), 32'd1);
    chk("n3_sel2_odata", 32'(if_c.Out_Data), 32'h52);
    chk("n3_sel2_osrc", 32'(if_c.Out_Src), 32'd2);
    $display("n3: src=%0d data=%h", if_c.Out_Src, if_c.Out_Data);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
